// File: rtl/bus_target_regbank.sv
// Bus responder fronting a small 32-bit register bank: ID, STATUS (sticky error
// flag plus access counter) and general RW registers. Register 2 drives ctrl_out.
module bus_target_regbank #(
    parameter logic [16:0] BASE_ADDR   = 17'h04000,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hD0BB_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] bus_addr,
    input  logic [31:0] bus_write_data,
    input  logic        bus_rd_en,
    input  logic        bus_wr_en,
    output logic [31:0] bus_read_data,
    output logic        bus_ack,
    output logic [31:0] ctrl_out,
    output logic        err_out
);

    localparam int unsigned Lsb  = $clog2(NUM_REGS * 4);
    localparam int unsigned IdxW = Lsb - 2;
    // Counter preload; guarded so WAIT_CYCLES=0 does not underflow.
    localparam logic [3:0] WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [15:0]       acc_cnt_q, acc_cnt_d;
    logic [31:0]       rw_q [NUM_REGS];
    logic [31:0]       rw_d [NUM_REGS];

    logic              hit;
    logic              req;
    logic [IdxW-1:0]   bus_idx;
    logic              unused_addr_bits;

    assign hit              = (bus_addr[16:Lsb] == BASE_ADDR[16:Lsb]);
    assign req              = (bus_rd_en | bus_wr_en) & hit;
    assign bus_idx          = bus_addr[Lsb-1:2];
    assign unused_addr_bits = ^bus_addr[1:0];

    // State and register bank storage with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            acc_cnt_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rw_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            acc_cnt_q <= acc_cnt_d;
            rw_q      <= rw_d;
        end
    end

    // Next-state: request capture, wait countdown, commit at ACK, hold until release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        err_d     = err_q;
        acc_cnt_d = acc_cnt_q;
        rw_d      = rw_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = bus_idx;
                    wdata_d = bus_write_data;
                    rd_d    = bus_rd_en;
                    wr_d    = bus_wr_en;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                // Withdrawal aborts silently; counter is left as is.
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d   = StHold;
                acc_cnt_d = acc_cnt_q + 16'd1;
                if (wr_q && !rd_q) begin
                    if (idx_q == IdxW'(1)) begin
                        if (wdata_q[0]) begin
                            err_d = 1'b0;
                        end
                    end else if (idx_q >= IdxW'(2)) begin
                        rw_d[idx_q] = wdata_q;
                    end
                end
                // Protocol error wins over any clear.
                if (rd_q && wr_q) begin
                    err_d = 1'b1;
                end
            end
            StHold: begin
                if (!bus_rd_en && !bus_wr_en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: ack and read data only in the ACK cycle, zero otherwise.
    always_comb begin
        bus_ack       = (state_q == StAck);
        bus_read_data = '0;
        if (state_q == StAck && rd_q && !wr_q) begin
            if (idx_q == IdxW'(0)) begin
                bus_read_data = ID_VALUE;
            end else if (idx_q == IdxW'(1)) begin
                bus_read_data = {acc_cnt_q, 15'b0, err_q};
            end else begin
                bus_read_data = rw_q[idx_q];
            end
        end
    end

    assign ctrl_out = rw_q[2];
    assign err_out  = err_q;

endmodule

// File: tb/tb_bus_target_regbank.sv
// Directed bench: a WAIT_CYCLES=2 instance for most checks, a WAIT_CYCLES=0
// instance for zero-wait latency and counter accumulation.
module tb_bus_target_regbank;

    localparam logic [31:0] Id = 32'hD0BB_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [16:0] a_addr, b_addr;
    logic [31:0] a_wd, b_wd;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_rdata, b_rdata, a_ctrl, b_ctrl;
    logic        a_ack, b_ack, a_err, b_err;

    int n_checks = 0;
    int n_fail   = 0;
    int stray_data = 0;
    int extra_ack  = 0;

    always #5 clk = ~clk;

    bus_target_regbank #(.WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .bus_addr(a_addr), .bus_write_data(a_wd),
        .bus_rd_en(a_rd), .bus_wr_en(a_wr), .bus_read_data(a_rdata),
        .bus_ack(a_ack), .ctrl_out(a_ctrl), .err_out(a_err)
    );

    bus_target_regbank #(.WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .bus_addr(b_addr), .bus_write_data(b_wd),
        .bus_rd_en(b_rd), .bus_wr_en(b_wr), .bus_read_data(b_rdata),
        .bus_ack(b_ack), .ctrl_out(b_ctrl), .err_out(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [16:0] addr, input logic r, input logic w,
                         input logic [31:0] wd);
        a_addr = sel ? '0 : addr;  a_rd = sel ? 1'b0 : r;  a_wr = sel ? 1'b0 : w;
        a_wd   = sel ? '0 : wd;
        b_addr = sel ? addr : '0;  b_rd = sel ? r : 1'b0;  b_wr = sel ? w : 1'b0;
        b_wd   = sel ? wd : '0;
    endtask

    // One complete transfer; lat is the cycle of ack (request cycle = 0), -1 if none.
    task automatic xfer(input bit sel, input logic [16:0] addr, input logic r, input logic w,
                        input logic [31:0] wd, output logic [31:0] rdata, output int lat);
        logic ack_s;
        logic [31:0] rd_s;
        @(negedge clk);
        drive(sel, addr, r, w, wd);
        lat   = -1;
        rdata = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            ack_s = sel ? b_ack : a_ack;
            rd_s  = sel ? b_rdata : a_rdata;
            if (lat < 0) begin
                if (ack_s) begin
                    lat   = c;
                    rdata = rd_s;
                    drive(sel, '0, 1'b0, 1'b0, '0);
                end else if (rd_s != 0) begin
                    stray_data++;
                end
            end else begin
                if (ack_s) extra_ack++;
                if (rd_s != 0) stray_data++;
                if (c >= lat + 2) break;
            end
        end
        drive(sel, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat;
        int acks;

        drive(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(a_ack), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_ctrl", a_ctrl, 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        rst = 1'b0;

        // ID read and latency
        xfer(1'b0, 17'h04000, 1'b1, 1'b0, '0, rd, lat);           // access 1
        check("id_lat", 32'(lat), 32'd3);
        check("id_data", rd, Id);

        // Write register 2, readback, status counter
        xfer(1'b0, 17'h04008, 1'b0, 1'b1, 32'hCAFE_F00D, rd, lat); // 2
        check("wr2_lat", 32'(lat), 32'd3);
        check("ctrl_out", a_ctrl, 32'hCAFE_F00D);
        xfer(1'b0, 17'h04008, 1'b1, 1'b0, '0, rd, lat);           // 3
        check("rd2_data", rd, 32'hCAFE_F00D);
        xfer(1'b0, 17'h04004, 1'b1, 1'b0, '0, rd, lat);           // 4, sees 3
        check("status_a", rd, 32'h0003_0000);

        // Enable held long after ack: single ack only
        @(negedge clk);
        drive(1'b0, 17'h0400C, 1'b1, 1'b0, '0);                    // 5
        acks = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (a_ack) acks++;
        end
        check("hold_acks", 32'(acks), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        xfer(1'b0, 17'h0400C, 1'b1, 1'b0, '0, rd, lat);           // 6
        check("rearm_lat", 32'(lat), 32'd3);
        check("rd3_data", rd, 32'd0);

        // Simultaneous rd/wr is an error: data 0, no write, sticky flag
        xfer(1'b0, 17'h04010, 1'b0, 1'b1, 32'h1234_5678, rd, lat); // 7
        xfer(1'b0, 17'h04010, 1'b1, 1'b1, 32'hFFFF_FFFF, rd, lat); // 8
        check("err_lat", 32'(lat), 32'd3);
        check("err_data", rd, 32'd0);
        check("err_set", 32'(a_err), 32'd1);
        xfer(1'b0, 17'h04010, 1'b1, 1'b0, '0, rd, lat);           // 9
        check("rd4_kept", rd, 32'h1234_5678);
        xfer(1'b0, 17'h04004, 1'b1, 1'b0, '0, rd, lat);           // 10, sees 9
        check("status_err", rd, 32'h0009_0001);
        xfer(1'b0, 17'h04004, 1'b0, 1'b1, 32'h0000_0001, rd, lat); // 11
        check("err_w1c", 32'(a_err), 32'd0);
        xfer(1'b0, 17'h04004, 1'b1, 1'b0, '0, rd, lat);           // 12, sees 11
        check("status_clr", rd, 32'h000B_0000);

        // Miss: never acked
        @(negedge clk);
        drive(1'b0, 17'h08000, 1'b1, 1'b0, '0);
        acks = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_ack) acks++;
        end
        check("miss_acks", 32'(acks), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);

        // Withdraw during WAIT: no ack, no write, no count
        @(negedge clk);
        drive(1'b0, 17'h04014, 1'b0, 1'b1, 32'h0000_AAAA);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        acks = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_ack) acks++;
        end
        check("wdraw_acks", 32'(acks), 32'd0);
        xfer(1'b0, 17'h04014, 1'b1, 1'b0, '0, rd, lat);           // 13
        check("wdraw_reg", rd, 32'd0);
        xfer(1'b0, 17'h04004, 1'b1, 1'b0, '0, rd, lat);           // 14, sees 13
        check("status_wdraw", rd, 32'h000D_0000);

        // Reset during WAIT of a write
        @(negedge clk);
        drive(1'b0, 17'h04018, 1'b0, 1'b1, 32'h0000_0055);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 32'(a_ack), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ctrl", a_ctrl, 32'd0);
        xfer(1'b0, 17'h04018, 1'b1, 1'b0, '0, rd, lat);
        check("rst_mid_lat", 32'(lat), 32'd3);
        check("rst_mid_reg", rd, 32'd0);

        // Zero-wait instance
        xfer(1'b1, 17'h04000, 1'b1, 1'b0, '0, rd, lat);           // 1
        check("w0_lat", 32'(lat), 32'd1);
        check("w0_id", rd, Id);
        for (int i = 0; i < 20; i++) begin
            xfer(1'b1, 17'h0400C, 1'b0, 1'b1, 32'(i), rd, lat);    // 2..21
        end
        xfer(1'b1, 17'h0400C, 1'b1, 1'b0, '0, rd, lat);           // 22
        check("w0_rd3", rd, 32'd19);
        xfer(1'b1, 17'h04004, 1'b1, 1'b0, '0, rd, lat);           // 23, sees 22
        check("w0_status", rd, 32'h0016_0000);

        check("stray_rdata", 32'(stray_data), 32'd0);
        check("extra_ack", 32'(extra_ack), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
